wb_hp_arb: RTL and testbench

Wishbone address decoder and transaction sequencer placed between the Caravel wishbone master and `NUM_CORES` `wb_hp` instances. It replaces OR-ing of the core responses with a single-outstanding-transaction controller. Each accepted request is routed to exactly one core. The controller waits for that core's ack or a timeout, then returns one registered response to the master. A local status register records timeouts for firmware debug.

---
 rtl/wb_hp_arb.sv | 187 ++++++++++++++++++
 tb/tb_wb_hp_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_hp_arb.sv
// Single-outstanding Wishbone sequencer: decodes each master request to one core,
// waits for that core's ack or a timeout, and returns one registered response.
module wb_hp_arb #(
  parameter int unsigned NUM_CORES     = 3,
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0000,
  parameter logic [31:0] STATUS_OFFSET = 32'h40,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  input  logic                      i_wb_we,
  input  logic [31:0]               i_wb_addr,
  input  logic [31:0]               i_wb_data,
  output logic                      o_wb_ack,
  output logic                      o_wb_stall,
  output logic [31:0]               o_wb_data,
  output logic [NUM_CORES-1:0]      c_wb_cyc,
  output logic [NUM_CORES-1:0]      c_wb_stb,
  output logic                      c_wb_we,
  output logic [31:0]               c_wb_addr,
  output logic [31:0]               c_wb_data,
  input  logic [NUM_CORES-1:0]      c_wb_ack,
  input  logic [NUM_CORES-1:0]      c_wb_stall,
  input  logic [32*NUM_CORES-1:0]   c_wb_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Counter value seen in the last ISSUE/WAIT cycle before the forced response.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [NUM_CORES-1:0]   sel_q, sel_d;
  logic [2:0]             tgt_q, tgt_d;
  logic [31:0]            resp_q, resp_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             tmo_count_q, tmo_count_d;
  logic [2:0]             tmo_core_q, tmo_core_d;

  logic [31:0]            off;
  logic                   core_hit;
  logic                   status_hit;
  logic                   accept;
  logic [NUM_CORES-1:0]   hit_onehot;
  logic                   sel_ack;
  logic                   sel_stall;
  logic [31:0]            rdata_masked [NUM_CORES];
  logic [31:0]            sel_rdata;
  logic                   timed_out;
  logic                   take_tmo;
  logic [31:0]            status_word;

  assign off        = i_wb_addr - BASE_ADDRESS;
  assign core_hit   = (off[1:0] == 2'b00) && ((off >> 2) < 32'(NUM_CORES));
  assign status_hit = (off == STATUS_OFFSET);
  assign accept     = i_wb_cyc && i_wb_stb && (state_q == S_IDLE);

  // Only the latched target's handshake and data are ever observed.
  assign sel_ack   = |(c_wb_ack & sel_q);
  assign sel_stall = |(c_wb_stall & sel_q);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign hit_onehot[gi]   = core_hit && (off[4:2] == 3'(gi));
      assign rdata_masked[gi] = c_wb_rdata[32*gi +: 32] & {32{sel_q[gi]}};
      assign c_wb_cyc[gi]     = sel_q[gi] && ((state_q == S_ISSUE) || (state_q == S_WAIT));
      assign c_wb_stb[gi]     = sel_q[gi] && (state_q == S_ISSUE);
    end
  endgenerate

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_rdata = sel_rdata | rdata_masked[i];
    end
  end

  assign timed_out   = (cnt_q == TMO_LAST);
  assign status_word = {16'h0, tmo_count_q, 5'h0, tmo_core_q};

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    tmo_count_d = tmo_count_q;
    tmo_core_d  = tmo_core_q;
    take_tmo    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = i_wb_we;
          addr_d  = i_wb_addr;
          wdata_d = i_wb_data;
          sel_d   = hit_onehot;
          tgt_d   = off[4:2];
          cnt_d   = '0;
          if (core_hit) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
            resp_d  = (status_hit && !i_wb_we) ? status_word : 32'h0;
          end
        end
      end
      S_ISSUE: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (timed_out) begin
          take_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (!sel_stall) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A master abort beats everything; an ack beats a coincident timeout.
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (sel_ack) begin
          state_d = S_RESP;
          resp_d  = we_q ? 32'h0 : sel_rdata;
        end else if (timed_out) begin
          take_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_tmo) begin
      state_d     = S_RESP;
      resp_d      = 32'hFFFF_FFFF;
      tmo_count_d = (tmo_count_q == 8'hFF) ? tmo_count_q : tmo_count_q + 8'd1;
      tmo_core_d  = tgt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      tgt_q       <= '0;
      resp_q      <= '0;
      cnt_q       <= '0;
      tmo_count_q <= '0;
      tmo_core_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
      tmo_count_q <= tmo_count_d;
      tmo_core_q  <= tmo_core_d;
    end
  end

  assign o_wb_ack   = (state_q == S_RESP);
  assign o_wb_stall = (state_q != S_IDLE);
  assign o_wb_data  = o_wb_ack ? resp_q : 32'h0;
  assign c_wb_we    = we_q;
  assign c_wb_addr  = addr_q;
  assign c_wb_data  = wdata_q;

endmodule

// File: tb/tb_wb_hp_arb.sv
// Scoreboard bench for wb_hp_arb: driver predicts each response from the address map
// and core timing, a monitor pops and compares on every o_wb_ack.
module tb_wb_hp_arb;
  localparam int          NC   = 3;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk;
  logic              reset_n;
  logic              i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]       i_wb_addr, i_wb_data;
  logic              o_wb_ack, o_wb_stall;
  logic [31:0]       o_wb_data;
  logic [NC-1:0]     c_wb_cyc, c_wb_stb;
  logic              c_wb_we;
  logic [31:0]       c_wb_addr, c_wb_data;
  logic [NC-1:0]     c_wb_ack, c_wb_stall;
  logic [32*NC-1:0]  c_wb_rdata;

  wb_hp_arb #(.NUM_CORES(NC), .BASE_ADDRESS(BASE), .STATUS_OFFSET(32'h40), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .c_wb_cyc(c_wb_cyc), .c_wb_stb(c_wb_stb), .c_wb_we(c_wb_we),
    .c_wb_addr(c_wb_addr), .c_wb_data(c_wb_data),
    .c_wb_ack(c_wb_ack), .c_wb_stall(c_wb_stall), .c_wb_rdata(c_wb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Configuration of the core currently being addressed (owned by the driver).
  int          cfg_tgt = -1;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_addr = '0, cfg_wdata = '0;
  int          cfg_s = 0, cfg_k = 1;
  bit          cfg_ack_en = 1'b0;
  int          cfg_id = 0;
  int          last_acc = 0;

  // Reference model of the status register.
  int m_tmo_cnt = 0;
  int m_tmo_core = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Monitor: scoreboard compare on every ack, plus per-cycle core-side checks.
  initial begin
    exp_t        e;
    logic [NC-1:0] allow;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        allow = '0;
        if (cfg_tgt >= 0) allow[cfg_tgt] = 1'b1;
        if (c_wb_cyc != '0) check("cyc_select", 128'(c_wb_cyc), 128'(allow));
        if (c_wb_stb != '0)
          check("core_request", {63'h0, c_wb_we, c_wb_addr, c_wb_data}, {63'h0, cfg_we, cfg_addr, cfg_wdata});
        if (o_wb_ack) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL spurious_ack: got ack data %0h expected no ack (cycle %0d)", o_wb_data, cyc_n);
          end else begin
            e = sb.pop_front();
            check("ack_data", 128'(o_wb_data), 128'(e.data));
            check("ack_cycle", 128'(cyc_n), 128'(e.exp_cyc));
            check("stall_at_ack", 128'(o_wb_stall), 128'(1));
          end
        end else if (sb.size() != 0 && cyc_n > sb[0].exp_cyc) begin
          e = sb.pop_front();
          n_cmp++; n_err++;
          $display("FAIL missing_ack: got no ack expected ack at cycle %0d data %0h", e.exp_cyc, e.data);
        end
      end
    end
  end

  // Core responder: target stalls cfg_s cycles then acks cfg_k cycles after its accepted stb;
  // other cores toggle ack/stall randomly and must be ignored.
  initial begin
    int stb_cnt = 0;
    int pending = -1;
    int seen_id = 0;
    c_wb_ack   = '0;
    c_wb_stall = '0;
    forever begin
      @(negedge clk);
      if (cfg_id != seen_id) begin
        seen_id = cfg_id;
        pending = -1;
        stb_cnt = 0;
      end
      for (int i = 0; i < NC; i++) begin
        c_wb_ack[i]   = ($urandom_range(0, 3) == 0);
        c_wb_stall[i] = 1'($urandom_range(0, 1));
      end
      if (cfg_tgt >= 0) begin
        c_wb_ack[cfg_tgt] = cfg_ack_en && (cyc_n == pending);
        if (c_wb_stb[cfg_tgt]) begin
          c_wb_stall[cfg_tgt] = (stb_cnt < cfg_s);
          if (stb_cnt >= cfg_s) pending = cyc_n + cfg_k;
          stb_cnt++;
        end else begin
          stb_cnt = 0;
        end
      end
    end
  end

  // One master transaction; called and returning on a falling edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int s, input int k, input bit ack_en, input logic [31:0] rdata,
                     input int abort_after, input bit do_reset);
    int          guard;
    logic [31:0] off;
    bit          is_core, is_status;
    int          lat;
    exp_t        e;
    guard = 0;
    while (o_wb_stall && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL idle_wait: got stall stuck high expected idle within 300 cycles");
    end
    off       = addr - BASE;
    is_core   = (off % 4 == 0) && (off / 4 < NC);
    is_status = (off == 32'h40);
    cfg_tgt    = is_core ? int'(off / 4) : -1;
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_wdata  = wdata;
    cfg_s      = s;
    cfg_k      = k;
    cfg_ack_en = ack_en;
    cfg_id++;
    for (int i = 0; i < NC; i++) c_wb_rdata[32*i +: 32] = $urandom;
    if (is_core) c_wb_rdata[32*cfg_tgt +: 32] = rdata;
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = wdata;
    last_acc  = cyc_n + 1;
    if (abort_after < 0 && !do_reset) begin
      if (is_core) begin
        if (ack_en && (s + 1 + k) <= TO) begin
          lat    = 2 + s + k;
          e.data = we ? 32'h0 : rdata;
        end else begin
          lat    = 1 + TO;
          e.data = 32'hFFFF_FFFF;
          if (m_tmo_cnt < 255) m_tmo_cnt++;
          m_tmo_core = cfg_tgt;
        end
      end else begin
        lat    = 1;
        e.data = (is_status && !we) ? {16'h0, 8'(m_tmo_cnt), 5'h0, 3'(m_tmo_core)} : 32'h0;
      end
      e.exp_cyc = last_acc + lat - 1;
      sb.push_back(e);
    end
    @(negedge clk);
    i_wb_stb  = 1'b0;
    i_wb_we   = 1'($urandom_range(0, 1));
    i_wb_addr = $urandom;
    i_wb_data = $urandom;
    if (abort_after >= 0) begin
      repeat (abort_after) @(negedge clk);
      i_wb_cyc = 1'b0;
      @(negedge clk);
      check("abort_cyc_drop", 128'(c_wb_cyc), 128'(0));
      check("abort_idle", 128'({o_wb_stall, o_wb_ack}), 128'(0));
      i_wb_cyc = 1'b1;
      repeat (k + 4) @(negedge clk);
    end
    if (do_reset) begin
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("reset_master_out", {94'h0, o_wb_ack, o_wb_stall, o_wb_data}, 128'(0));
      check("reset_core_out", {57'h0, c_wb_cyc, c_wb_stb, c_wb_we, c_wb_addr, c_wb_data}, 128'(0));
      m_tmo_cnt  = 0;
      m_tmo_core = 0;
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    int          acc_a;
    int          kind, t, guard;
    logic [31:0] unmapped [6];
    unmapped[0] = BASE + 32'hC;  unmapped[1] = BASE + 32'h1;  unmapped[2] = BASE + 32'h6;
    unmapped[3] = BASE - 32'h4;  unmapped[4] = 32'h4000_0000; unmapped[5] = BASE + 32'h44;

    reset_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0;
    c_wb_rdata = '0;
    repeat (2) @(negedge clk);
    check("init_master_out", {94'h0, o_wb_ack, o_wb_stall, o_wb_data}, 128'(0));
    check("init_core_out", {57'h0, c_wb_cyc, c_wb_stb, c_wb_we, c_wb_addr, c_wb_data}, 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    txn(1'b0, BASE + 32'h4, 32'h0, 0, 2, 1'b1, 32'hCAFE_0001, -1, 1'b0);   // core read
    txn(1'b1, BASE + 32'h8, 32'h55, 3, 1, 1'b1, 32'h1234_5678, -1, 1'b0); // stalled write
    txn(1'b0, BASE, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);                  // timeout
    txn(1'b0, BASE + 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);         // status
    txn(1'b0, BASE + 32'hC, 32'h0, 0, 1, 1'b1, 32'h0, -1, 1'b0);          // unmapped
    acc_a = last_acc;
    txn(1'b0, BASE, 32'h0, 0, 1, 1'b1, 32'hA5A5_0000, -1, 1'b0);          // back-to-back
    check("b2b_accept_gap", 128'(last_acc - acc_a), 128'(2));
    txn(1'b0, BASE + 32'h4, 32'h0, 0, 15, 1'b1, 32'hB00B_0015, -1, 1'b0); // ack at the limit
    txn(1'b0, BASE + 32'h8, 32'h0, 2, 14, 1'b1, 32'hB00B_0016, -1, 1'b0); // one past the limit
    txn(1'b0, BASE + 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);
    txn(1'b0, BASE + 32'h4, 32'h0, 0, 8, 1'b1, 32'hDEAD_0001, 2, 1'b0);   // abort in WAIT
    txn(1'b1, BASE + 32'h8, 32'h77, 10, 1, 1'b1, 32'h0, 2, 1'b0);         // abort in ISSUE
    txn(1'b1, BASE + 32'h40, 32'h99, 0, 1, 1'b0, 32'h0, -1, 1'b0);        // status write
    txn(1'b0, BASE + 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);
    txn(1'b0, BASE + 32'h8, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b1);          // reset mid-WAIT
    txn(1'b0, BASE + 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        t = $urandom_range(0, NC - 1);
        txn(1'($urandom_range(0, 1)), BASE + 32'(4 * t), $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(1, 5),
            ($urandom_range(0, 9) != 0), $urandom, -1, 1'b0);
      end else if (kind <= 7) begin
        txn(1'($urandom_range(0, 1)), BASE + 32'h40, $urandom, 0, 1, 1'b0, 32'h0, -1, 1'b0);
      end else begin
        txn(1'($urandom_range(0, 1)), unmapped[$urandom_range(0, 5)], $urandom, 0, 1, 1'b0, 32'h0, -1, 1'b0);
      end
    end

    for (int n = 0; n < 256; n++) begin
      txn(1'b0, BASE + 32'(4 * (n % NC)), 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);
    end
    txn(1'b0, BASE + 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, -1, 1'b0);         // saturated count

    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
